// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory initiator.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

  // Size code 11 has no legal alignment, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = ofs[0];
      SZ_WORD: bad = (ofs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication and load lane select/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_ofs,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_ofs,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted_s;

  assign shifted_s = ld_word >> {ld_ofs, 3'b000};

  // Store side: enables follow the byte offset, data is replicated to every lane.
  always_comb begin
    st_be    = 4'b1111;
    st_lanes = 32'h0000_0000;
    if (st_we) begin
      case (st_size)
        SZ_BYTE: begin
          st_be    = 4'b0001 << st_ofs;
          st_lanes = {4{st_wdata[7:0]}};
        end
        SZ_HALF: begin
          st_be    = 4'b0011 << st_ofs;
          st_lanes = {2{st_wdata[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_lanes = st_wdata;
        end
      endcase
    end else begin
      st_be    = 4'b1111;
      st_lanes = 32'h0000_0000;
    end
  end

  // Load side: pick the addressed lanes and extend to a full word.
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & shifted_s[15]}}, shifted_s[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator between the CPU memory stage and data memory.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       lat_size_r, lat_ofs_r;
  logic             lat_signed_r, lat_we_r;
  logic             misaligned_s, timeout_s, start_s;
  logic [3:0]       st_be_s;
  logic [31:0]      st_lanes_s, ld_data_s;
  logic             cpu_done_r, cpu_err_r, mem_req_valid_r, mem_we_r;
  logic [31:0]      cpu_rdata_r, mem_addr_r, mem_wdata_r;
  logic [3:0]       mem_be_r;

  assign misaligned_s = is_misaligned(cpu_size, cpu_addr[1:0]);
  // Counter reaching TIMEOUT on this edge means TIMEOUT cycles spent in REQ+WAIT.
  assign timeout_s    = (cnt_r == CNT_LAST);
  assign start_s      = (state_r == IDLE) && (state_nxt_s == REQ);

  lsu_lane_align u_align (
    .st_we     (cpu_we),
    .st_size   (cpu_size),
    .st_ofs    (cpu_addr[1:0]),
    .st_wdata  (cpu_wdata),
    .st_be     (st_be_s),
    .st_lanes  (st_lanes_s),
    .ld_size   (lat_size_r),
    .ld_ofs    (lat_ofs_r),
    .ld_signed (lat_signed_r),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) state_nxt_s = misaligned_s ? ERR : REQ;
        else         state_nxt_s = IDLE;
      end
      REQ: begin
        if (timeout_s)          state_nxt_s = ERR;
        else if (mem_req_ready) state_nxt_s = WAIT;
        else                    state_nxt_s = REQ;
      end
      WAIT: begin
        if (mem_resp_valid) state_nxt_s = RESP;
        else if (timeout_s) state_nxt_s = ERR;
        else                state_nxt_s = WAIT;
      end
      RESP:    state_nxt_s = IDLE;
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, timeout counter, latched access and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      lat_size_r      <= 2'b00;
      lat_ofs_r       <= 2'b00;
      lat_signed_r    <= 1'b0;
      lat_we_r        <= 1'b0;
      cpu_done_r      <= 1'b0;
      cpu_err_r       <= 1'b0;
      cpu_rdata_r     <= 32'h0000_0000;
      mem_req_valid_r <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= 32'h0000_0000;
      mem_be_r        <= 4'b0000;
      mem_wdata_r     <= 32'h0000_0000;
    end else begin
      state_r         <= state_nxt_s;
      if (start_s)                                  cnt_r <= '0;
      else if ((state_r == REQ) || (state_r == WAIT)) cnt_r <= cnt_r + CNT_ONE;
      else                                          cnt_r <= cnt_r;
      if (start_s) begin
        lat_size_r   <= cpu_size;
        lat_ofs_r    <= cpu_addr[1:0];
        lat_signed_r <= cpu_signed;
        lat_we_r     <= cpu_we;
        mem_we_r     <= cpu_we;
        mem_addr_r   <= {cpu_addr[31:2], 2'b00};
        mem_be_r     <= st_be_s;
        mem_wdata_r  <= st_lanes_s;
      end else if (state_nxt_s != REQ) begin
        mem_we_r     <= 1'b0;
        mem_addr_r   <= 32'h0000_0000;
        mem_be_r     <= 4'b0000;
        mem_wdata_r  <= 32'h0000_0000;
      end
      mem_req_valid_r <= (state_nxt_s == REQ);
      cpu_done_r      <= (state_nxt_s == RESP);
      cpu_err_r       <= (state_nxt_s == ERR);
      cpu_rdata_r     <= ((state_nxt_s == RESP) && !lat_we_r) ? ld_data_s : 32'h0000_0000;
    end
  end

  assign cpu_stall     = cpu_req & ~cpu_done_r & ~cpu_err_r;
  assign cpu_done      = cpu_done_r;
  assign cpu_err       = cpu_err_r;
  assign cpu_rdata     = cpu_rdata_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_be        = mem_be_r;
  assign mem_wdata     = mem_wdata_r;

endmodule
